// File: rtl/doom58_pkg.sv
// Shared screen geometry and types for the 160x120 VGA adapter path.
package doom58_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wa_state_t;

    function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: search starts one past the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(pointer) + k) % NUM_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates pixel writes from several requesters onto one VGA adapter port,
// with a full-screen fill mode that takes over the port for one frame.
//
// state    | meaning
// ST_IDLE  | round-robin arbitration of pixel requests; clear_start starts a fill
// ST_CLEAR | one fill pixel per cycle, raster order; requests and clear_start ignored
module vga_write_arbiter
    import doom58_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear_start,
    input  logic [COLOUR_W-1:0]         clear_colour,
    output logic                        clear_busy,
    output logic                        clear_done,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [X_W*NUM_REQ-1:0]      req_x,
    input  logic [Y_W*NUM_REQ-1:0]      req_y,
    input  logic [COLOUR_W*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]          grant,
    output logic [X_W-1:0]              vga_x,
    output logic [Y_W-1:0]              vga_y,
    output logic [COLOUR_W-1:0]         vga_colour,
    output logic                        vga_write
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wa_state_t           state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  rr_grant;
    logic [X_W-1:0]      fill_x;
    logic [Y_W-1:0]      fill_y;
    logic [COLOUR_W-1:0] fill_colour;

    logic [PTR_W-1:0]    sel_idx;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (rr_ptr),
        .grant   (rr_grant)
    );

    // A pending clear_start takes the port, so no requester is acknowledged that cycle.
    assign grant = (state == ST_IDLE && !clear_start && !reset) ? rr_grant : '0;

    always_comb begin
        sel_idx    = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx    = PTR_W'(i);
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            fill_x      <= '0;
            fill_y      <= '0;
            fill_colour <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_write   <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        // Pixel (0,0) goes out straight away; the counters hold the next pixel.
                        fill_colour <= clear_colour;
                        fill_x      <= X_W'(1);
                        fill_y      <= '0;
                        vga_x       <= '0;
                        vga_y       <= '0;
                        vga_colour  <= clear_colour;
                        vga_write   <= 1'b1;
                        clear_busy  <= 1'b1;
                        state       <= ST_CLEAR;
                    end else begin
                        clear_busy <= 1'b0;
                        if (|grant) begin
                            rr_ptr     <= sel_idx;
                            vga_x      <= sel_x;
                            vga_y      <= sel_y;
                            vga_colour <= sel_colour;
                            vga_write  <= in_bounds(sel_x, sel_y);
                        end else begin
                            vga_write <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    vga_x      <= fill_x;
                    vga_y      <= fill_y;
                    vga_colour <= fill_colour;
                    vga_write  <= 1'b1;
                    clear_busy <= 1'b1;
                    if (fill_x == X_W'(SCREEN_W - 1) && fill_y == Y_W'(SCREEN_H - 1)) begin
                        clear_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (fill_x == X_W'(SCREEN_W - 1)) begin
                        fill_x <= '0;
                        fill_y <= fill_y + Y_W'(1);
                    end else begin
                        fill_x <= fill_x + X_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
